// File: rtl/regfile_read_port.sv
// Operand-fetch buffer for the 16x16 register file: selects A/B sources with
// same-cycle write forwarding and holds the pair in a one-entry valid/ready stage.
module regfile_read_port #(
    parameter int WIDTH    = 16,
    parameter int GAME_REG = 15,
    parameter int STALL_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   r0,
    input  logic [WIDTH-1:0]   r1,
    input  logic [WIDTH-1:0]   r2,
    input  logic [WIDTH-1:0]   r3,
    input  logic [WIDTH-1:0]   r4,
    input  logic [WIDTH-1:0]   r5,
    input  logic [WIDTH-1:0]   r6,
    input  logic [WIDTH-1:0]   r7,
    input  logic [WIDTH-1:0]   r8,
    input  logic [WIDTH-1:0]   r9,
    input  logic [WIDTH-1:0]   r10,
    input  logic [WIDTH-1:0]   r11,
    input  logic [WIDTH-1:0]   r12,
    input  logic [WIDTH-1:0]   r13,
    input  logic [WIDTH-1:0]   r14,
    input  logic [WIDTH-1:0]   r15,
    input  logic [WIDTH-1:0]   ALUBus,
    input  logic [15:0]        regEnable,
    input  logic [WIDTH-1:0]   gameInput,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [3:0]         srcA,
    input  logic [3:0]         srcB,
    output logic [WIDTH-1:0]   opA,
    output logic [WIDTH-1:0]   opB,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [1:0]         fwd_hit,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic [3:0] GAME_IDX = 4'(GAME_REG);

    logic [0:0]       state;
    logic [WIDTH-1:0] regs [16];
    logic [WIDTH-1:0] sel_a_p0;
    logic [WIDTH-1:0] sel_b_p0;
    logic             hit_a_p0;
    logic             hit_b_p0;
    logic             accept;
    logic             pop;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    assign regs[0]  = r0;
    assign regs[1]  = r1;
    assign regs[2]  = r2;
    assign regs[3]  = r3;
    assign regs[4]  = r4;
    assign regs[5]  = r5;
    assign regs[6]  = r6;
    assign regs[7]  = r7;
    assign regs[8]  = r8;
    assign regs[9]  = r9;
    assign regs[10] = r10;
    assign regs[11] = r11;
    assign regs[12] = r12;
    assign regs[13] = r13;
    assign regs[14] = r14;
    assign regs[15] = r15;

    assign op_valid = (state == FULL);
    assign rd_ready = (state == EMPTY) || op_ready;
    assign accept   = rd_valid && rd_ready;
    assign pop      = op_valid && op_ready;

    // Stage p0: source select; the game register always reloads, so its write enable is moot
    always_comb begin
        sel_a_p0 = regs[srcA];
        hit_a_p0 = 1'b0;
        if (srcA == GAME_IDX) begin
            sel_a_p0 = gameInput;
            hit_a_p0 = 1'b1;
        end else if (regEnable[srcA]) begin
            sel_a_p0 = ALUBus;
            hit_a_p0 = 1'b1;
        end

        sel_b_p0 = regs[srcB];
        hit_b_p0 = 1'b0;
        if (srcB == GAME_IDX) begin
            sel_b_p0 = gameInput;
            hit_b_p0 = 1'b1;
        end else if (regEnable[srcB]) begin
            sel_b_p0 = ALUBus;
            hit_b_p0 = 1'b1;
        end
    end

    // Stage p1: output buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            opA       <= '0;
            opB       <= '0;
            fwd_hit   <= 2'b00;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                state   <= FULL;
                opA     <= sel_a_p0;
                opB     <= sel_b_p0;
                fwd_hit <= {hit_b_p0, hit_a_p0};
            end else if (pop) begin
                state <= EMPTY;
            end
            if (op_valid && !op_ready)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: forwarding, backpressure with stall
// saturation, streaming and mid-stream reset.
module tb_regfile_read_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] r [16];
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic [15:0] gameInput;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  fwd_hit;
    logic [7:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_read_port dut (
        .clk(clk), .reset(reset),
        .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
        .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
        .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]),
        .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
        .ALUBus(ALUBus), .regEnable(regEnable), .gameInput(gameInput),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .srcA(srcA), .srcB(srcB),
        .opA(opA), .opB(opB), .op_valid(op_valid), .op_ready(op_ready),
        .fwd_hit(fwd_hit), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ea;
        logic [15:0] eb;
        for (int i = 0; i < 16; i++) r[i] = 16'h0000;
        reset = 1'b1; ALUBus = '0; regEnable = '0; gameInput = '0;
        rd_valid = 1'b1; op_ready = 1'b1; srcA = 4'd0; srcB = 4'd0;

        // reset held with a pending request
        tick(); tick();
        check("rst_valid", op_valid, 0);
        check("rst_opA", opA, 0);
        check("rst_opB", opB, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_fwd", fwd_hit, 0);

        // plain register read
        reset = 1'b0;
        r[3] = 16'h1234; r[7] = 16'h00FF; srcA = 4'd3; srcB = 4'd7;
        #1 check("empty_ready", rd_ready, 1);
        tick();
        check("rd_valid", op_valid, 1);
        check("rd_opA", opA, 16'h1234);
        check("rd_opB", opB, 16'h00FF);
        check("rd_fwd", fwd_hit, 2'b00);

        // same-cycle write forwarding, srcA==srcB
        r[5] = 16'h0001; regEnable = 16'h0020; ALUBus = 16'hBEEF; srcA = 4'd5; srcB = 4'd5;
        tick();
        check("fw_opA", opA, 16'hBEEF);
        check("fw_opB", opB, 16'hBEEF);
        check("fw_hit", fwd_hit, 2'b11);

        // game register wins over its write enable; unrelated enable ignored
        r[15] = 16'h1111; r[2] = 16'h2222; gameInput = 16'h00A5;
        regEnable = 16'h8010; ALUBus = 16'h0000; srcA = 4'd15; srcB = 4'd2;
        tick();
        check("game_opA", opA, 16'h00A5);
        check("game_opB", opB, 16'h2222);
        check("game_fwd", fwd_hit, 2'b01);

        // backpressure: held pair, saturating stall counter
        regEnable = '0; r[1] = 16'hAAAA; srcA = 4'd1; srcB = 4'd2; op_ready = 1'b0;
        #1 check("bp_ready", rd_ready, 0);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 10)  check("stall_10", stall_cnt, 10);
            if (i == 254) check("stall_254", stall_cnt, 254);
            if (i == 255) check("stall_255", stall_cnt, 255);
        end
        check("stall_sat", stall_cnt, 255);
        check("bp_opA", opA, 16'h00A5);
        check("bp_opB", opB, 16'h2222);
        check("bp_valid", op_valid, 1);
        check("bp_fwd", fwd_hit, 2'b01);
        op_ready = 1'b1;
        #1 check("release_ready", rd_ready, 1);
        tick();
        check("rel_valid", op_valid, 1);
        check("rel_opA", opA, 16'hAAAA);
        check("rel_opB", opB, 16'h2222);
        check("rel_stall", stall_cnt, 255);

        // pop without a new request empties the buffer
        rd_valid = 1'b0;
        tick();
        check("pop_empty", op_valid, 0);

        // streaming, one pair per cycle
        for (int i = 0; i < 16; i++) r[i] = 16'h1000 + 16'(i);
        gameInput = 16'h5A5A; rd_valid = 1'b1; op_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i); srcB = 4'(15 - i);
            ea = (i == 15) ? 16'h5A5A : 16'h1000 + 16'(i);
            eb = (i == 0)  ? 16'h5A5A : 16'h1000 + 16'(15 - i);
            #1 check("st_ready", rd_ready, 1);
            tick();
            check("st_valid", op_valid, 1);
            check("st_opA", opA, ea);
            check("st_opB", opB, eb);
        end

        // reset mid-stream drops the held pair
        reset = 1'b1;
        tick();
        check("mid_rst_valid", op_valid, 0);
        check("mid_rst_opA", opA, 0);
        check("mid_rst_stall", stall_cnt, 0);
        reset = 1'b0; rd_valid = 1'b0;
        tick();
        check("post_rst_valid", op_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
